// File: rtl/cpu_clock_gen.sv
// rtl/cpu_clock_gen.sv - quadrature E/Q CPU clock and video/CPU frame counter generator
module cpu_clock_gen #(
  parameter  int SLOW_DIV  = 16,
  parameter  int FAST_DIV  = 8,
  parameter  int TURBO_DIV = 4,
  localparam int TW        = $clog2(SLOW_DIV)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    rate_sel,
  input  logic          addr_slow,
  input  logic          is_ram,
  output logic          E,
  output logic          Q,
  output logic [TW-1:0] T,
  output logic [TW-1:0] phase,
  output logic          cycle_start,
  output logic [1:0]    cur_rate,
  output logic          stretch,
  output logic          vid_slot
);

  // Encodings of the executing cycle length, as seen on cur_rate.
  // Code 2'b01 never appears here: the address-dependent request
  // resolves to slow or fast before it is stored.
  localparam logic [1:0] RATE_SLOW  = 2'b00;
  localparam logic [1:0] RATE_FAST  = 2'b10;
  localparam logic [1:0] RATE_TURBO = 2'b11;

  localparam logic [TW-1:0] PH_ONE = TW'(1);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // Last phase of a cycle of the given length (N-1). Because every length
  // is a power of two, this doubles as the alignment mask applied to T.
  function automatic logic [TW-1:0] f_last(input logic [1:0] rate);
    case (rate)
      RATE_FAST:  f_last = TW'(FAST_DIV - 1);
      RATE_TURBO: f_last = TW'(TURBO_DIV - 1);
      default:    f_last = TW'(SLOW_DIV - 1);
    endcase
  endfunction

  // Phase at which E rises (N/2).
  function automatic logic [TW-1:0] f_half(input logic [1:0] rate);
    case (rate)
      RATE_FAST:  f_half = TW'(FAST_DIV / 2);
      RATE_TURBO: f_half = TW'(TURBO_DIV / 2);
      default:    f_half = TW'(SLOW_DIV / 2);
    endcase
  endfunction

  // Phase at which Q rises (N/4).
  function automatic logic [TW-1:0] f_q1(input logic [1:0] rate);
    case (rate)
      RATE_FAST:  f_q1 = TW'(FAST_DIV / 4);
      RATE_TURBO: f_q1 = TW'(TURBO_DIV / 4);
      default:    f_q1 = TW'(SLOW_DIV / 4);
    endcase
  endfunction

  // Phase at which Q falls (3N/4).
  function automatic logic [TW-1:0] f_q3(input logic [1:0] rate);
    case (rate)
      RATE_FAST:  f_q3 = TW'((3 * FAST_DIV) / 4);
      RATE_TURBO: f_q3 = TW'((3 * TURBO_DIV) / 4);
      default:    f_q3 = TW'((3 * SLOW_DIV) / 4);
    endcase
  endfunction

  // Architectural state
  state_t        r_state;
  logic [TW-1:0] r_t;
  logic [TW-1:0] r_phase;
  logic [1:0]    r_rate;
  logic          r_ram_lat;

  // Registered outputs
  logic          r_cycle_start;
  logic          r_e;
  logic          r_q;
  logic          r_vid;

  // Next-state values
  state_t        w_state_nxt;
  logic [TW-1:0] w_t_nxt;
  logic [TW-1:0] w_phase_nxt;
  logic [1:0]    w_rate_nxt;
  logic          w_ram_nxt;
  logic          w_cs_nxt;
  logic          w_e_nxt;
  logic          w_q_nxt;
  logic          w_vid_nxt;

  // Decision helpers
  logic [1:0]    w_req_rate;
  logic [TW-1:0] w_req_mask;
  logic          w_decide;
  logic          w_aligned;
  logic          w_steal;

  // Resolve the speed request into the length of the next cycle.
  always_comb begin
    w_req_rate = RATE_SLOW;
    case (rate_sel)
      2'b00:   w_req_rate = RATE_SLOW;
      2'b01:   w_req_rate = addr_slow ? RATE_SLOW : RATE_FAST;
      2'b10:   w_req_rate = RATE_FAST;
      default: w_req_rate = RATE_TURBO;
    endcase
  end

  // A decision is taken on the last tick of a cycle, or every tick while waiting.
  // The requested cycle may start next tick only if the frame counter will
  // then sit on a multiple of its length, i.e. the low bits of T are all ones.
  assign w_decide   = (r_state == ST_WAIT) || (r_phase == f_last(r_rate));
  assign w_req_mask = f_last(w_req_rate);
  assign w_aligned  = ((r_t & w_req_mask) == w_req_mask);

  // The frame counter is free running and wraps naturally at SLOW_DIV.
  assign w_t_nxt = r_t + PH_ONE;

  // State register: all architectural state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_t           <= '0;
      r_phase       <= '0;
      r_rate        <= RATE_SLOW;
      r_ram_lat     <= 1'b0;
      r_cycle_start <= 1'b0;
      r_e           <= 1'b0;
      r_q           <= 1'b0;
      r_vid         <= 1'b1;
    end else begin
      r_state       <= w_state_nxt;
      r_t           <= w_t_nxt;
      r_phase       <= w_phase_nxt;
      r_rate        <= w_rate_nxt;
      r_ram_lat     <= w_ram_nxt;
      r_cycle_start <= w_cs_nxt;
      r_e           <= w_e_nxt;
      r_q           <= w_q_nxt;
      r_vid         <= w_vid_nxt;
    end
  end

  // Next-state logic: advance the phase or decide between a new cycle and a stretch.
  // The executing length is kept while waiting; it only changes when an
  // aligned cycle actually starts.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase + PH_ONE;
    w_rate_nxt  = r_rate;
    w_ram_nxt   = r_ram_lat;
    w_cs_nxt    = 1'b0;
    if (w_decide) begin
      w_phase_nxt = '0;
      if (w_aligned) begin
        w_state_nxt = ST_RUN;
        w_rate_nxt  = w_req_rate;
        w_ram_nxt   = is_ram;
        w_cs_nxt    = 1'b1;
      end else begin
        w_state_nxt = ST_WAIT;
      end
    end
  end

  // Output logic: derive next E/Q/vid_slot from the next state so the
  // registered outputs always line up with the registered phase and T.
  always_comb begin
    w_e_nxt = 1'b0;
    w_q_nxt = 1'b0;
    if (w_state_nxt == ST_RUN) begin
      w_e_nxt = (w_phase_nxt >= f_half(w_rate_nxt));
      w_q_nxt = (w_phase_nxt >= f_q1(w_rate_nxt)) &&
                (w_phase_nxt <  f_q3(w_rate_nxt));
    end
    // A shortened DRAM cycle borrows the video half of the frame.
    w_steal   = (w_state_nxt == ST_RUN) &&
                (f_last(w_rate_nxt) != TW'(SLOW_DIV - 1)) &&
                w_ram_nxt;
    w_vid_nxt = ~w_t_nxt[TW-1] && ~w_steal;
  end

  assign E           = r_e;
  assign Q           = r_q;
  assign T           = r_t;
  assign phase       = r_phase;
  assign cycle_start = r_cycle_start;
  assign cur_rate    = r_rate;
  assign stretch     = (r_state == ST_WAIT);
  assign vid_slot    = r_vid;

endmodule

// File: tb/tb_cpu_clock_gen.sv
// tb/tb_cpu_clock_gen.sv - scoreboard bench for cpu_clock_gen
module tb_cpu_clock_gen;

  localparam int SLOW  = 16;
  localparam int FAST  = 8;
  localparam int TURBO = 4;
  localparam int TW    = 4;
  localparam int OW    = 2 * TW + 7;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    rate_sel = 2'b00;
  logic          addr_slow = 1'b0;
  logic          is_ram = 1'b0;
  logic          E, Q, cycle_start, stretch, vid_slot;
  logic [TW-1:0] T, phase;
  logic [1:0]    cur_rate;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int m_t, m_ph, m_n;
  bit m_wait, m_ram, m_cs;

  logic [OW-1:0] sb[$];

  cpu_clock_gen #(.SLOW_DIV(SLOW), .FAST_DIV(FAST), .TURBO_DIV(TURBO)) dut (
    .clk(clk), .rst(rst), .rate_sel(rate_sel), .addr_slow(addr_slow), .is_ram(is_ram),
    .E(E), .Q(Q), .T(T), .phase(phase), .cycle_start(cycle_start),
    .cur_rate(cur_rate), .stretch(stretch), .vid_slot(vid_slot)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_t = 0; m_ph = 0; m_n = SLOW; m_wait = 0; m_ram = 0; m_cs = 0;
    sb.delete();
  endtask

  task automatic model_step();
    int nn;
    bit decide;
    decide = m_wait || (m_ph == m_n - 1);
    m_cs = 0;
    if (decide) begin
      case (rate_sel)
        2'b00:   nn = SLOW;
        2'b01:   nn = addr_slow ? SLOW : FAST;
        2'b10:   nn = FAST;
        default: nn = TURBO;
      endcase
      m_ph = 0;
      if ((m_t + 1) % nn == 0) begin
        m_wait = 0; m_n = nn; m_cs = 1; m_ram = is_ram;
      end else begin
        m_wait = 1;
      end
    end else begin
      m_ph = m_ph + 1;
    end
    m_t = (m_t + 1) % SLOW;
  endtask

  function automatic logic [OW-1:0] model_vec();
    logic e, q, vid;
    logic [1:0] r;
    e   = !m_wait && (m_ph >= m_n / 2);
    q   = !m_wait && (m_ph >= m_n / 4) && (m_ph < (3 * m_n) / 4);
    vid = (m_t < SLOW / 2) && !(!m_wait && (m_n < SLOW) && m_ram);
    r   = (m_n == SLOW) ? 2'b00 : (m_n == FAST) ? 2'b10 : 2'b11;
    return {TW'(m_t), TW'(m_ph), e, q, m_cs, r, m_wait, vid};
  endfunction

  // one clock: push the model's prediction, then pop it against the DUT
  task automatic tick();
    logic [OW-1:0] exp_v, obs_v;
    model_step();
    sb.push_back(model_vec());
    @(posedge clk); #1;
    obs_v = {T, phase, E, Q, cycle_start, cur_rate, stretch, vid_slot};
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got no entry want one");
    end else begin
      exp_v = sb.pop_front();
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL scoreboard T/ph/E/Q/cs/rate/st/vid: got %b want %b", obs_v, exp_v);
      end
    end
  endtask

  task automatic run_to(input int tgt);
    for (int i = 0; i < 64 && m_t != tgt; i++) tick();
  endtask

  task automatic run_until_start(input int n);
    for (int i = 0; i < 64 && !(m_n == n && !m_wait && m_t == 0); i++) tick();
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    n_tests++; if ({E, Q} !== 2'b00) begin n_fail++; $display("FAIL reset_eq: got %b want 00", {E, Q}); end
    n_tests++; if (T !== 4'd0) begin n_fail++; $display("FAIL reset_t: got %0d want 0", T); end
    n_tests++; if (phase !== 4'd0) begin n_fail++; $display("FAIL reset_phase: got %0d want 0", phase); end
    n_tests++; if (cycle_start !== 1'b0) begin n_fail++; $display("FAIL reset_cs: got %b want 0", cycle_start); end
    n_tests++; if (cur_rate !== 2'b00) begin n_fail++; $display("FAIL reset_rate: got %b want 00", cur_rate); end
    n_tests++; if (stretch !== 1'b0) begin n_fail++; $display("FAIL reset_stretch: got %b want 0", stretch); end
    n_tests++; if (vid_slot !== 1'b1) begin n_fail++; $display("FAIL reset_vid: got %b want 1", vid_slot); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_slow();
    logic [4:0] exp_v;
    rate_sel = 2'b00;
    for (int i = 0; i < 32; i++) begin
      tick();
      exp_v = {m_t >= 8, (m_t >= 4) && (m_t < 12), m_t == 0, m_t < 8, 1'b0};
      n_tests++;
      if ({E, Q, cycle_start, vid_slot, stretch} !== exp_v) begin
        n_fail++;
        $display("FAIL slow_eq t=%0d: got %b want %b", m_t, {E, Q, cycle_start, vid_slot, stretch}, exp_v);
      end
    end
  endtask

  task automatic test_slow_to_fast();
    run_to(5);
    rate_sel = 2'b10;
    run_to(15);
    n_tests++;
    if ({cur_rate, E} !== 3'b001) begin n_fail++; $display("FAIL s2f_still_slow: got %b want 001", {cur_rate, E}); end
    tick();
    n_tests++;
    if ({cycle_start, cur_rate, stretch} !== 4'b1100) begin
      n_fail++; $display("FAIL s2f_start: got %b want 1100", {cycle_start, cur_rate, stretch});
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      n_tests++;
      if ({cycle_start, E, cur_rate} !== {(m_t == 0) || (m_t == 8), (m_t % 8) >= 4, 2'b10}) begin
        n_fail++; $display("FAIL fast_cycle t=%0d: got %b", m_t, {cycle_start, E, cur_rate});
      end
    end
  endtask

  task automatic test_turbo_to_slow();
    rate_sel = 2'b11; is_ram = 1'b1;
    run_until_start(TURBO);
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (vid_slot !== 1'b0) begin n_fail++; $display("FAIL turbo_ram_vid t=%0d: got %b want 0", m_t, vid_slot); end
      if (i < 5) tick();
    end
    rate_sel = 2'b00;
    tick(); tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      n_tests++;
      if ({stretch, E, Q} !== 3'b100) begin n_fail++; $display("FAIL t2s_wait t=%0d: got %b want 100", m_t, {stretch, E, Q}); end
    end
    tick();
    n_tests++;
    if ({cycle_start, cur_rate} !== 3'b100) begin n_fail++; $display("FAIL t2s_start: got %b want 100", {cycle_start, cur_rate}); end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (vid_slot !== 1'b1) begin n_fail++; $display("FAIL t2s_vid t=%0d: got %b want 1", m_t, vid_slot); end
      if (i < 7) tick();
    end
    is_ram = 1'b0;
  endtask

  task automatic test_addr_dep();
    logic [1:0] exp_rate;
    int starts;
    rate_sel = 2'b01; addr_slow = 1'b0;
    exp_rate = 2'b10;
    starts = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (m_cs) begin
        starts++;
        n_tests++;
        if ({cycle_start, cur_rate, T} !== {1'b1, exp_rate, 4'd0}) begin
          n_fail++; $display("FAIL addr_dep_start: got %b want %b", {cycle_start, cur_rate, T}, {1'b1, exp_rate, 4'd0});
        end
        exp_rate = (exp_rate == 2'b10) ? 2'b00 : 2'b10;
        addr_slow = ~addr_slow;
      end
    end
    n_tests++;
    if (starts < 4) begin n_fail++; $display("FAIL addr_dep_count: got %0d want >=4", starts); end
  endtask

  task automatic test_turbo_to_fast();
    rate_sel = 2'b11;
    run_until_start(TURBO);
    tick();
    rate_sel = 2'b10;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if ({stretch, E, Q} !== 3'b100) begin n_fail++; $display("FAIL t2f_wait t=%0d: got %b want 100", m_t, {stretch, E, Q}); end
    end
    tick();
    n_tests++;
    if ({cycle_start, cur_rate, T} !== {1'b1, 2'b10, 4'd8}) begin
      n_fail++; $display("FAIL t2f_start: got %b want 1108", {cycle_start, cur_rate, T});
    end
    for (int i = 0; i < 7; i++) begin
      tick();
      n_tests++;
      if (E !== (m_t >= 12)) begin n_fail++; $display("FAIL t2f_e t=%0d: got %b", m_t, E); end
    end
  endtask

  task automatic test_reset_mid();
    int first_e;
    rate_sel = 2'b10;
    run_until_start(FAST);
    run_to(10);
    rst = 1'b1;
    #2;
    n_tests++;
    if ({E, Q, T, phase, cycle_start, cur_rate, stretch, vid_slot} !== {2'b00, 4'd0, 4'd0, 1'b0, 2'b00, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL reset_mid_async: got %b", {E, Q, T, phase, cycle_start, cur_rate, stretch, vid_slot});
    end
    @(posedge clk); @(posedge clk); #1;
    n_tests++;
    if ({T, phase} !== 8'd0) begin n_fail++; $display("FAIL reset_mid_hold: got %b want 0", {T, phase}); end
    rst = 1'b0;
    model_reset();
    first_e = -1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (E && first_e < 0) first_e = m_t;
    end
    n_tests++;
    if (first_e != 8) begin n_fail++; $display("FAIL reset_mid_first_e: got %0d want 8", first_e); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_slow();
    test_slow_to_fast();
    test_turbo_to_slow();
    test_addr_dep();
    test_turbo_to_fast();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
